// File: rtl/tlp_arb_pkg.sv
// rtl/tlp_arb_pkg.sv - shared types and constants for the TLP transmit arbiter
// Contents: source-select enum, arbiter state enum, default widths,
// credit counter width, run counter width and its saturating increment.
package tlp_arb_pkg;

    localparam int HDR_W_DEF  = 96;
    localparam int DATA_W_DEF = 128;
    localparam int CRD_W      = 8;
    localparam int RUN_W      = 4;

    typedef enum logic {
        SRC_P   = 1'b0,
        SRC_CPL = 1'b1
    } tlp_src_e;

    typedef enum logic {
        OWN_P   = 1'b0,
        OWN_CPL = 1'b1
    } arb_state_e;

    // Run counter saturates so a long uncontested streak never wraps back
    // below the weight and accidentally starves the other class.
    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] r);
        return (&r) ? r : r + 1'b1;
    endfunction

endpackage

// File: rtl/tlp_crd_counter.sv
// rtl/tlp_crd_counter.sv - per-class flow-control credit counter
// Ports: clk, rst_n (async, active-high), consume (credit used by an accept),
// ret (credit returned), cnt (current credits), nonzero (cnt != 0),
// err (sticky: return arrived while already holding INIT credits).
module tlp_crd_counter
    import tlp_arb_pkg::*;
#(
    parameter int INIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             consume,
    input  logic             ret,
    output logic [CRD_W-1:0] cnt,
    output logic             nonzero,
    output logic             err
);

    localparam logic [CRD_W-1:0] INIT_V = CRD_W'(INIT);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt <= INIT_V;
            err <= 1'b0;
        end else if (consume && !ret) begin
            cnt <= cnt - 1'b1;
        end else if (ret && !consume) begin
            // A return with nothing outstanding is a link-partner bug:
            // keep the count sane and flag it until the next reset.
            if (cnt == INIT_V) begin
                err <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign nonzero = |cnt;

endmodule

// File: rtl/tlp_tx_arbiter.sv
// rtl/tlp_tx_arbiter.sv - weighted round-robin P/CPL arbiter onto the TLP tx port
// Ports: clk, rst_n (async, active-high); P and CPL requesters
// (valid/ready/hdr/data) plus credit-return pulses; registered output
// tlp_valid/tlp_ready/tlp_hdr/tlp_data/tlp_src; p_crd/cpl_crd credit counts;
// crd_err sticky credit-overflow flag.
// Optional macro TLP_ARB_STATS_EN adds p_grant_cnt, cpl_grant_cnt, stall_cnt.
module tlp_tx_arbiter
    import tlp_arb_pkg::*;
#(
    parameter int HDR_W        = HDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int P_CRD_INIT   = 8,
    parameter int CPL_CRD_INIT = 8,
    parameter int P_WEIGHT     = 2,
    parameter int CPL_WEIGHT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_valid,
    output logic              p_ready,
    input  logic [HDR_W-1:0]  p_hdr,
    input  logic [DATA_W-1:0] p_data,
    input  logic              cpl_valid,
    output logic              cpl_ready,
    input  logic [HDR_W-1:0]  cpl_hdr,
    input  logic [DATA_W-1:0] cpl_data,
    input  logic              p_crd_ret,
    input  logic              cpl_crd_ret,
    output logic              tlp_valid,
    input  logic              tlp_ready,
    output logic [HDR_W-1:0]  tlp_hdr,
    output logic [DATA_W-1:0] tlp_data,
    output logic              tlp_src,
    output logic [CRD_W-1:0]  p_crd,
    output logic [CRD_W-1:0]  cpl_crd,
    output logic              crd_err
`ifdef TLP_ARB_STATS_EN
    ,
    output logic [31:0]       p_grant_cnt,
    output logic [31:0]       cpl_grant_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [RUN_W-1:0] P_WT   = RUN_W'(P_WEIGHT);
    localparam logic [RUN_W-1:0] CPL_WT = RUN_W'(CPL_WEIGHT);

    arb_state_e       state, state_n;
    logic [RUN_W-1:0] run, run_n;
    logic             grant_p, grant_c;
    logic             p_nz, c_nz, p_err, c_err;
    logic             p_elig, c_elig, slot_free;
    tlp_src_e         src_q;

    assign p_elig    = p_valid && p_nz;
    assign c_elig    = cpl_valid && c_nz;
    assign slot_free = !tlp_valid || tlp_ready;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= OWN_P;
            run   <= '0;
        end else begin
            state <= state_n;
            run   <= run_n;
        end
    end

    // The weight only caps a streak while the other class is waiting;
    // an uncontested owner keeps the port with no idle gaps.
    always_comb begin
        state_n = state;
        run_n   = run;
        grant_p = 1'b0;
        grant_c = 1'b0;
        if (slot_free && !rst_n) begin
            case (state)
                OWN_P: begin
                    if (p_elig && (!c_elig || run < P_WT)) begin
                        grant_p = 1'b1;
                        run_n   = run_inc(run);
                    end else if (c_elig) begin
                        grant_c = 1'b1;
                        state_n = OWN_CPL;
                        run_n   = RUN_W'(1);
                    end
                end
                OWN_CPL: begin
                    if (c_elig && (!p_elig || run < CPL_WT)) begin
                        grant_c = 1'b1;
                        run_n   = run_inc(run);
                    end else if (p_elig) begin
                        grant_p = 1'b1;
                        state_n = OWN_P;
                        run_n   = RUN_W'(1);
                    end
                end
                default: begin
                    state_n = OWN_P;
                    run_n   = '0;
                end
            endcase
        end
    end

    assign p_ready   = grant_p;
    assign cpl_ready = grant_c;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tlp_valid <= 1'b0;
            tlp_hdr   <= '0;
            tlp_data  <= '0;
            src_q     <= SRC_P;
        end else if (grant_p || grant_c) begin
            tlp_valid <= 1'b1;
            tlp_hdr   <= grant_c ? cpl_hdr  : p_hdr;
            tlp_data  <= grant_c ? cpl_data : p_data;
            src_q     <= grant_c ? SRC_CPL  : SRC_P;
        end else if (tlp_ready) begin
            tlp_valid <= 1'b0;
        end
    end

    assign tlp_src = src_q;

    tlp_crd_counter #(.INIT(P_CRD_INIT)) u_p_crd (
        .clk     (clk),
        .rst_n   (rst_n),
        .consume (grant_p),
        .ret     (p_crd_ret),
        .cnt     (p_crd),
        .nonzero (p_nz),
        .err     (p_err)
    );

    tlp_crd_counter #(.INIT(CPL_CRD_INIT)) u_cpl_crd (
        .clk     (clk),
        .rst_n   (rst_n),
        .consume (grant_c),
        .ret     (cpl_crd_ret),
        .cnt     (cpl_crd),
        .nonzero (c_nz),
        .err     (c_err)
    );

    assign crd_err = p_err | c_err;

`ifdef TLP_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            p_grant_cnt   <= '0;
            cpl_grant_cnt <= '0;
            stall_cnt     <= '0;
        end else begin
            if (grant_p)
                p_grant_cnt <= p_grant_cnt + 32'd1;
            if (grant_c)
                cpl_grant_cnt <= cpl_grant_cnt + 32'd1;
            if (tlp_valid && !tlp_ready)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// tb/tb_tlp_tx_arbiter.sv - self-checking bench for tlp_tx_arbiter
module tb_tlp_tx_arbiter;

    localparam int HDR_W  = 96;
    localparam int DATA_W = 128;
    localparam int P_INIT = 8;
    localparam int C_INIT = 8;
    localparam int P_WT   = 2;
    localparam int C_WT   = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              p_valid = 1'b0, cpl_valid = 1'b0;
    logic              p_ready, cpl_ready;
    logic [HDR_W-1:0]  p_hdr = '0, cpl_hdr = '0;
    logic [DATA_W-1:0] p_data = '0, cpl_data = '0;
    logic              p_crd_ret = 1'b0, cpl_crd_ret = 1'b0;
    logic              tlp_valid, tlp_src;
    logic              tlp_ready = 1'b0;
    logic [HDR_W-1:0]  tlp_hdr;
    logic [DATA_W-1:0] tlp_data;
    logic [7:0]        p_crd, cpl_crd;
    logic              crd_err;
`ifdef TLP_ARB_STATS_EN
    logic [31:0]       p_grant_cnt, cpl_grant_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    tlp_tx_arbiter #(
        .HDR_W(HDR_W), .DATA_W(DATA_W), .P_CRD_INIT(P_INIT),
        .CPL_CRD_INIT(C_INIT), .P_WEIGHT(P_WT), .CPL_WEIGHT(C_WT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p_valid(p_valid), .p_ready(p_ready), .p_hdr(p_hdr), .p_data(p_data),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_hdr(cpl_hdr), .cpl_data(cpl_data),
        .p_crd_ret(p_crd_ret), .cpl_crd_ret(cpl_crd_ret),
        .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_hdr(tlp_hdr),
        .tlp_data(tlp_data), .tlp_src(tlp_src),
        .p_crd(p_crd), .cpl_crd(cpl_crd), .crd_err(crd_err)
`ifdef TLP_ARB_STATS_EN
        , .p_grant_cnt(p_grant_cnt), .cpl_grant_cnt(cpl_grant_cnt), .stall_cnt(stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks who won last and how long the current streak
    // is, plus credits and the output slot contents.
    int                m_pc, m_cc, m_streak;
    bit                m_last, m_tv, m_src, m_err;
    logic [HDR_W-1:0]  m_hdr;
    logic [DATA_W-1:0] m_data;
    bit                s_pr, s_cr;

    task automatic model_reset();
        m_pc = P_INIT; m_cc = C_INIT; m_streak = 0; m_last = 1'b0;
        m_tv = 1'b0; m_src = 1'b0; m_err = 1'b0; m_hdr = '0; m_data = '0;
    endtask

    function automatic int model_pick();
        bit pe, ce;
        int w;
        if (m_tv && !tlp_ready) return -1;
        pe = p_valid && (m_pc > 0);
        ce = cpl_valid && (m_cc > 0);
        if (pe && ce) begin
            w = m_last ? C_WT : P_WT;
            if (m_streak >= w) return m_last ? 0 : 1;
            return m_last ? 1 : 0;
        end
        if (pe) return 0;
        if (ce) return 1;
        return -1;
    endfunction

    task automatic model_commit(input int pick);
        int pb, cb;
        pb = m_pc; cb = m_cc;
        if (pick == 0) m_pc--;
        if (pick == 1) m_cc--;
        if (p_crd_ret) begin
            if (pb == P_INIT && pick != 0) m_err = 1'b1; else m_pc++;
        end
        if (cpl_crd_ret) begin
            if (cb == C_INIT && pick != 1) m_err = 1'b1; else m_cc++;
        end
        if (pick >= 0) begin
            m_tv   = 1'b1;
            m_src  = (pick == 1);
            m_hdr  = (pick == 1) ? cpl_hdr : p_hdr;
            m_data = (pick == 1) ? cpl_data : p_data;
            if ((pick == 1) == m_last) m_streak++;
            else begin m_streak = 1; m_last = (pick == 1); end
        end else if (tlp_ready) begin
            m_tv = 1'b0;
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the
    // next falling edge.
    task automatic step_model();
        int pick;
        #2;
        pick = model_pick();
        check("p_ready", 128'(p_ready), 128'(pick == 0));
        check("cpl_ready", 128'(cpl_ready), 128'(pick == 1));
        s_pr = p_ready; s_cr = cpl_ready;
        @(posedge clk);
        model_commit(pick);
        #1;
        check("tlp_valid", 128'(tlp_valid), 128'(m_tv));
        check("tlp_hdr", 128'(tlp_hdr), 128'(m_hdr));
        check("tlp_data", 128'(tlp_data), 128'(m_data));
        check("tlp_src", 128'(tlp_src), 128'(m_src));
        check("p_crd", 128'(p_crd), 128'(m_pc));
        check("cpl_crd", 128'(cpl_crd), 128'(m_cc));
        check("crd_err", 128'(crd_err), 128'(m_err));
        @(negedge clk);
    endtask

    task automatic rand_payload();
        p_hdr    = {$urandom, $urandom, $urandom};
        p_data   = {$urandom, $urandom, $urandom, $urandom};
        cpl_hdr  = {$urandom, $urandom, $urandom};
        cpl_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        p_valid = 1'b0; cpl_valid = 1'b0; tlp_ready = 1'b0;
        p_crd_ret = 1'b0; cpl_crd_ret = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit pv, cv, rdy, pret, cret;
        bit e_pr, e_cr, e_tv, e_src;
        int e_pc, e_cc;
    } vec_t;

    vec_t tbl[14];
    int   acc;
    logic [HDR_W-1:0] held_hdr;
`ifdef TLP_ARB_STATS_EN
    logic [31:0] stall0;
`endif

    initial begin
        tbl[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 7,8};
        tbl[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 6,8};
        tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1, 6,7};
        tbl[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 5,7};
        tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 4,7};
        tbl[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1, 4,6};
        tbl[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1, 4,6};
        tbl[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1, 4,5};
        tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1, 4,4};
        tbl[9]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0, 3,4};
        tbl[10] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0, 3,4};
        tbl[11] = '{1'b1,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b1, 3,4};
        tbl[12] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1, 4,4};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1, 4,4};

        // Reset values
        do_reset();
        #2;
        check("rst p_ready", 128'(p_ready), 128'(0));
        check("rst cpl_ready", 128'(cpl_ready), 128'(0));
        check("rst tlp_valid", 128'(tlp_valid), 128'(0));
        check("rst tlp_hdr", 128'(tlp_hdr), 128'(0));
        check("rst tlp_data", 128'(tlp_data), 128'(0));
        check("rst tlp_src", 128'(tlp_src), 128'(0));
        check("rst p_crd", 128'(p_crd), 128'(P_INIT));
        check("rst cpl_crd", 128'(cpl_crd), 128'(C_INIT));
        check("rst crd_err", 128'(crd_err), 128'(0));
        @(negedge clk);

        // Table: weighted sequence, stall, same-cycle consume+return
        for (int i = 0; i < 14; i++) begin
            p_valid = tbl[i].pv; cpl_valid = tbl[i].cv; tlp_ready = tbl[i].rdy;
            p_crd_ret = tbl[i].pret; cpl_crd_ret = tbl[i].cret;
            rand_payload();
            #2;
            check($sformatf("tbl%0d p_ready", i), 128'(p_ready), 128'(tbl[i].e_pr));
            check($sformatf("tbl%0d cpl_ready", i), 128'(cpl_ready), 128'(tbl[i].e_cr));
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d tlp_valid", i), 128'(tlp_valid), 128'(tbl[i].e_tv));
            check($sformatf("tbl%0d tlp_src", i), 128'(tlp_src), 128'(tbl[i].e_src));
            check($sformatf("tbl%0d p_crd", i), 128'(p_crd), 128'(tbl[i].e_pc));
            check($sformatf("tbl%0d cpl_crd", i), 128'(cpl_crd), 128'(tbl[i].e_cc));
            @(negedge clk);
        end

        // Only P valid: 10 offered, 8 accepted; two returns allow 2 more
        do_reset();
        p_valid = 1'b1; tlp_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            rand_payload();
            step_model();
            if (s_pr) acc++;
            if (i >= 8) check("p_ready after credits out", 128'(s_pr), 128'(0));
        end
        check("P accepts with 8 credits", 128'(acc), 128'(8));
        check("p_crd exhausted", 128'(p_crd), 128'(0));
        acc = 0;
        for (int j = 0; j < 6; j++) begin
            p_crd_ret = (j < 2);
            rand_payload();
            step_model();
            if (s_pr) acc++;
        end
        p_crd_ret = 1'b0;
        check("P accepts after 2 returns", 128'(acc), 128'(2));

        // Output held stable for 5 stalled cycles
        do_reset();
        p_valid = 1'b1; cpl_valid = 1'b1; tlp_ready = 1'b1;
        rand_payload();
        step_model();
        held_hdr = tlp_hdr;
        tlp_ready = 1'b0;
`ifdef TLP_ARB_STATS_EN
        stall0 = stall_cnt;
`endif
        for (int i = 0; i < 5; i++) begin
            rand_payload();
            step_model();
            check("stall p_ready", 128'(s_pr), 128'(0));
            check("stall cpl_ready", 128'(s_cr), 128'(0));
            check("stall hdr stable", 128'(tlp_hdr), 128'(held_hdr));
        end
`ifdef TLP_ARB_STATS_EN
        check("stall_cnt", 128'(stall_cnt - stall0), 128'(5));
`endif

        // Return at INIT: counter unchanged, crd_err sticky until reset
        do_reset();
        p_crd_ret = 1'b1;
        step_model();
        p_crd_ret = 1'b0;
        check("p_crd at INIT after ret", 128'(p_crd), 128'(P_INIT));
        check("crd_err set", 128'(crd_err), 128'(1));
        repeat (3) step_model();
        check("crd_err sticky", 128'(crd_err), 128'(1));

        // Reset mid-burst with tlp_valid high
        tlp_ready = 1'b1; p_valid = 1'b1; cpl_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            step_model();
        end
        check("burst tlp_valid", 128'(tlp_valid), 128'(1));
        #2;
        rst_n = 1'b1;
        #1;
        check("midrst tlp_valid", 128'(tlp_valid), 128'(0));
        check("midrst p_crd", 128'(p_crd), 128'(P_INIT));
        check("midrst cpl_crd", 128'(cpl_crd), 128'(C_INIT));
        check("midrst crd_err", 128'(crd_err), 128'(0));
        check("midrst p_ready", 128'(p_ready), 128'(0));
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        rand_payload();
        step_model();
        check("first grant after reset is P", 128'(s_pr), 128'(1));
        check("no CPL grant after reset", 128'(s_cr), 128'(0));

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            p_valid     = ($urandom_range(0, 9) < 7);
            cpl_valid   = ($urandom_range(0, 9) < 7);
            tlp_ready   = ($urandom_range(0, 9) < 6);
            p_crd_ret   = (m_pc < P_INIT) && ($urandom_range(0, 3) == 0);
            cpl_crd_ret = (m_cc < C_INIT) && ($urandom_range(0, 3) == 0);
            rand_payload();
            step_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
